// File: rtl/data_sampler_mc.sv
// Multi-channel decimating sampler: each channel holds its latest (or first) input
// and releases it on the shared sample tick, counting every lost word per channel.
module data_sampler_mc #(
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        valid_i,
  input  logic [DIV_W-1:0]         div_i,
  input  logic                     mode_i,
  input  logic                     drop_clr_i,
  output logic [NUM_CH*DATA_W-1:0] data_o,
  output logic [NUM_CH-1:0]        valid_o,
  output logic                     tick_o,
  output logic [NUM_CH*DROP_W-1:0] drop_cnt_o
);

  logic [DIV_W-1:0]  cnt;
  logic              term;
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] drop;

  // >= rather than == so a lowered div_i never wraps through the full range
  assign term = (cnt >= div_i);
  assign drop = valid_i & pend & {NUM_CH{~term}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt    <= term ? '0 : cnt + DIV_W'(1);
      tick_o <= term;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      valid_o    <= '0;
      data_o     <= '0;
      drop_cnt_o <= '0;
      for (int c = 0; c < NUM_CH; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        valid_o[c] <= term & pend[c];
        if (term && pend[c])
          data_o[c*DATA_W +: DATA_W] <= hold[c];
        // keep-first drops leave the held word alone
        if (valid_i[c] && !(drop[c] && mode_i))
          hold[c] <= data_i[c*DATA_W +: DATA_W];
        pend[c] <= valid_i[c] | (pend[c] & ~term);
        if (drop_clr_i)
          drop_cnt_o[c*DROP_W +: DROP_W] <= '0;
        else if (drop[c] && (drop_cnt_o[c*DROP_W +: DROP_W] != {DROP_W{1'b1}}))
          drop_cnt_o[c*DROP_W +: DROP_W] <= drop_cnt_o[c*DROP_W +: DROP_W] + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_sampler_mc.sv
// Scoreboard bench for data_sampler_mc: a cycle-level reference model predicts
// every output word and tick; a negedge monitor pops and compares.
module tb_data_sampler_mc;
  localparam int DATA_W = 64;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int DROP_W = 16;
  localparam int SAT_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        valid_i;
  logic [DIV_W-1:0]         div_i;
  logic                     mode_i;
  logic                     drop_clr_i;

  logic [NUM_CH*DATA_W-1:0] data_o;
  logic [NUM_CH-1:0]        valid_o;
  logic                     tick_o;
  logic [NUM_CH*DROP_W-1:0] drop_cnt_o;

  logic [NUM_CH*DATA_W-1:0] s_data_o;
  logic [NUM_CH-1:0]        s_valid_o;
  logic                     s_tick_o;
  logic [NUM_CH*SAT_W-1:0]  s_drop_cnt_o;

  data_sampler_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DROP_W(DROP_W)) u_dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .div_i(div_i),
    .mode_i(mode_i), .drop_clr_i(drop_clr_i), .data_o(data_o), .valid_o(valid_o),
    .tick_o(tick_o), .drop_cnt_o(drop_cnt_o));

  data_sampler_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DROP_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .div_i(div_i),
    .mode_i(mode_i), .drop_clr_i(drop_clr_i), .data_o(s_data_o), .valid_o(s_valid_o),
    .tick_o(s_tick_o), .drop_cnt_o(s_drop_cnt_o));

  typedef struct {
    int                edge_no;
    int                ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state: period position, held word and pending flag per channel,
  // and the number of drops since the last clear (saturation applied on compare)
  int                m_cnt;
  logic              m_pend [NUM_CH];
  logic [DATA_W-1:0] m_hold [NUM_CH];
  int                m_raw  [NUM_CH];

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 1'b0;
      m_hold[c] = '0;
      m_raw[c]  = 0;
    end
    exp_q.delete();
    tick_q.delete();
  endtask

  // predicts what the edge numbered e does with the inputs currently driven
  task automatic model_step(input int e);
    bit   term;
    exp_t x;
    term = (m_cnt >= int'(div_i));
    if (term) tick_q.push_back(e);
    for (int c = 0; c < NUM_CH; c++) begin
      if (term && m_pend[c]) begin
        x.edge_no = e;
        x.ch      = c;
        x.data    = m_hold[c];
        exp_q.push_back(x);
      end
      if (valid_i[c]) begin
        if (!term && m_pend[c]) begin
          m_raw[c]++;
          if (!mode_i) m_hold[c] = data_i[c*DATA_W +: DATA_W];
        end else begin
          m_hold[c] = data_i[c*DATA_W +: DATA_W];
        end
        m_pend[c] = 1'b1;
      end else if (term) begin
        m_pend[c] = 1'b0;
      end
    end
    if (drop_clr_i)
      for (int c = 0; c < NUM_CH; c++) m_raw[c] = 0;
    m_cnt = term ? 0 : m_cnt + 1;
  endtask

  task automatic check_drops();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("drop_cnt[%0d]", c), 64'(drop_cnt_o[c*DROP_W +: DROP_W]), 64'(sat(m_raw[c], DROP_W)));
      check($sformatf("sat_drop_cnt[%0d]", c), 64'(s_drop_cnt_o[c*SAT_W +: SAT_W]), 64'(sat(m_raw[c], SAT_W)));
    end
  endtask

  task automatic apply(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                       input int dv, input logic m, input logic clr);
    check_drops();
    valid_i    = v;
    data_i     = d;
    div_i      = DIV_W'(dv);
    mode_i     = m;
    drop_clr_i = clr;
    model_step(edge_n + 1);
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                       input int dv, input logic m, input logic clr);
    apply(v, d, dv, m, clr);
    @(negedge clk);
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] put(input int c, input logic [DATA_W-1:0] v);
    logic [NUM_CH*DATA_W-1:0] r;
    r = '0;
    r[c*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  // asynchronous reset asserted in the high phase, well away from the edge
  task automatic reset_mid();
    apply('0, '0, int'(div_i), mode_i, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_data_o_nonzero", 64'(data_o != '0), 64'd0);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_tick_o", 64'(tick_o), 64'd0);
    check("rst_drop_cnt_nonzero", 64'(drop_cnt_o != '0), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic et, ev;
    if (!rst) begin
      et = (tick_q.size() > 0) && (tick_q[0] == edge_n);
      check("tick_o", 64'(tick_o), 64'(et));
      if (et) void'(tick_q.pop_front());
      for (int c = 0; c < NUM_CH; c++) begin
        ev = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_n) && (exp_q[0].ch == c);
        check($sformatf("valid_o[%0d]", c), 64'(valid_o[c]), 64'(ev));
        if (ev) begin
          check($sformatf("data_o[%0d]", c), data_o[c*DATA_W +: DATA_W], exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_CH*DATA_W-1:0] rd;
    logic [NUM_CH-1:0]        rv;
    int dv, dens;
    logic md;

    rst = 1'b1; valid_i = '0; data_i = '0; div_i = '0; mode_i = 1'b0; drop_clr_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset while a word is pending, then the first tick must carry nothing
    cycle('0, '0, 200, 1'b0, 1'b0);
    cycle(4'b0001, put(0, 64'h99), 200, 1'b0, 1'b0);
    cycle('0, '0, 200, 1'b0, 1'b0);
    reset_mid();
    for (int i = 0; i < 4; i++) cycle('0, '0, 3, 1'b0, 1'b0);
    check("first_tick", 64'(tick_o), 64'd1);
    check("first_tick_valid", 64'(valid_o), 64'd0);

    // keep-latest
    reset_mid();
    cycle(4'b0001, put(0, 64'h11), 3, 1'b0, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    cycle(4'b0001, put(0, 64'h22), 3, 1'b0, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    check("basic_data", data_o[63:0], 64'h22);
    check("basic_valid", 64'(valid_o), 64'b0001);
    check("basic_drop0", 64'(drop_cnt_o[15:0]), 64'd1);
    check("basic_drop_others", 64'(drop_cnt_o[63:16]), 64'd0);

    // keep-first
    reset_mid();
    cycle(4'b0001, put(0, 64'h11), 3, 1'b1, 1'b0);
    cycle('0, '0, 3, 1'b1, 1'b0);
    cycle(4'b0001, put(0, 64'h22), 3, 1'b1, 1'b0);
    cycle('0, '0, 3, 1'b1, 1'b0);
    check("keepfirst_data", data_o[63:0], 64'h11);
    check("keepfirst_drop0", 64'(drop_cnt_o[15:0]), 64'd1);

    // input landing on the terminal cycle is not a drop
    reset_mid();
    cycle(4'b0010, put(1, 64'h55), 3, 1'b0, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    cycle(4'b0010, put(1, 64'hAA), 3, 1'b0, 1'b0);
    check("simul_first", data_o[127:64], 64'h55);
    check("simul_valid", 64'(valid_o), 64'b0010);
    for (int i = 0; i < 4; i++) cycle('0, '0, 3, 1'b0, 1'b0);
    check("simul_second", data_o[127:64], 64'hAA);
    check("simul_drop1", 64'(drop_cnt_o[31:16]), 64'd0);

    // div_i=0: full throughput, two-cycle latency
    reset_mid();
    for (int i = 1; i <= 20; i++) begin
      cycle(4'hF, {NUM_CH{64'(i)}}, 0, 1'b0, 1'b0);
      if (i >= 2) begin
        check("thru_data", data_o[DATA_W*NUM_CH-1 -: DATA_W], 64'(i - 1));
        check("thru_valid", 64'(valid_o), 64'hF);
      end
    end
    check("thru_drops_nonzero", 64'(drop_cnt_o != '0), 64'd0);

    // saturation, clear-over-drop, divider lowered below cnt
    reset_mid();
    for (int j = 0; j < 6; j++) cycle(4'b0100, put(2, 64'(100 + j)), 200, 1'b0, 1'b0);
    check("sat_cnt", 64'(s_drop_cnt_o[5:4]), 64'd3);
    check("wide_cnt", 64'(drop_cnt_o[47:32]), 64'd5);
    cycle(4'b0100, put(2, 64'h77), 200, 1'b0, 1'b1);
    check("clr_drop_sat", 64'(s_drop_cnt_o[5:4]), 64'd0);
    check("clr_drop_wide", 64'(drop_cnt_o[47:32]), 64'd0);
    for (int i = 0; i < 43; i++) cycle('0, '0, 200, 1'b0, 1'b0);
    check("pre_divchg_tick", 64'(tick_o), 64'd0);
    cycle('0, '0, 5, 1'b0, 1'b0);
    check("divchg_tick", 64'(tick_o), 64'd1);
    check("divchg_data", data_o[191:128], 64'h77);

    // randomized segments
    for (int seg = 0; seg < 10; seg++) begin
      dv   = (seg == 9) ? 30 : $urandom_range(0, 7);
      md   = 1'($urandom_range(0, 1));
      dens = $urandom_range(1, 8);
      if (seg == 5) reset_mid();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 63) == 0) dv = $urandom_range(0, 12);
        for (int c = 0; c < NUM_CH; c++) begin
          rv[c] = ($urandom_range(0, 7) < dens);
          rd[c*DATA_W +: DATA_W] = {$urandom(), $urandom()};
        end
        cycle(rv, rd, dv, md, ($urandom_range(0, 31) == 0));
      end
    end

    for (int i = 0; i < 6; i++) cycle('0, '0, 0, 1'b0, 1'b0);
    #1;
    check_drops();
    check("leftover_words", 64'(exp_q.size()), 64'd0);
    check("leftover_ticks", 64'(tick_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
